nfc_rdata_checker: RTL
======================

NFC_RDATA_CHECKER -- requirements
Module: nfc_rdata_checker

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, read-stream data width in bits (multiple of 32).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1048576, idle-cycle limit while checking.
REQ-003 SHALL have port clk, input, 1, the single clock (xdma clock domain).
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port i_start, input, 1, one-cycle start pulse.
REQ-006 SHALL have port i_seed, input, 32, initial pattern value, nonzero.
REQ-007 SHALL have port i_len, input, 24, expected transfer length in bytes.
REQ-008 SHALL have ports s_axis_tvalid (in, 1), s_axis_tready (out, 1), s_axis_tdata (in, DATA_WIDTH), s_axis_tkeep (in, DATA_WIDTH/8) and s_axis_tlast (in, 1), the read-data stream from the channel's m_axis.
REQ-009 SHALL have port o_busy, output, 1, high while checking.
REQ-010 SHALL have port o_done, output, 1, one-cycle completion pulse.
REQ-011 SHALL have port o_pass, output, 1, result of the last run.
REQ-012 SHALL have ports o_err_cnt (out, 16, mismatched bytes, saturating) and o_first_err (out, 24, byte offset of the first mismatch).
REQ-013 SHALL have ports o_byte_cnt (out, 24, bytes accepted), o_len_err (out, 1) and o_timeout (out, 1).

Function
REQ-014 SHALL implement the states IDLE, RUN and DONE.
REQ-015 IDLE->RUN on i_start; latch i_len; load the pattern register with i_seed; clear counters, o_first_err, o_len_err and o_timeout.
REQ-016 If i_len==0 at start, SHALL go IDLE->DONE, accept no beats, and report pass=1.
REQ-017 SHALL drive s_axis_tready=1 only in RUN; a beat is accepted when tvalid&&tready.
REQ-018 Expected pattern: each 32-bit lane k of a beat SHALL equal the lane-k output of a Galois LFSR (x^32+x^22+x^2+x+1), advanced once per lane in lane order.
REQ-019 On an accepted beat, the LFSR SHALL advance DATA_WIDTH/32 steps.
REQ-020 Compares SHALL be per byte, only where tkeep=1; masked bytes are neither compared nor counted.
REQ-021 On each accepted beat, o_byte_cnt SHALL increase by popcount(tkeep).
REQ-022 On each accepted beat, o_err_cnt SHALL increase by the mismatch count, saturating at 0xFFFF.
REQ-023 o_first_err SHALL latch o_byte_cnt plus the lowest mismatching byte index, on the first mismatch only.
REQ-024 RUN->DONE on an accepted beat with tlast=1.
REQ-025 On that tlast beat, o_len_err=1 if the post-beat byte count != i_len.
REQ-026 RUN->DONE on an accepted beat that brings the byte count to >= i_len without tlast; o_len_err=1.
REQ-027 RUN->DONE when TIMEOUT_CYC consecutive RUN cycles pass with no accepted beat; o_timeout=1.
REQ-028 DONE lasts exactly one cycle, with o_done=1, then returns to IDLE.
REQ-029 o_done SHALL rise the cycle after the final beat is accepted.
REQ-030 o_pass = (err_cnt==0)&&!o_len_err&&!o_timeout; it is updated in DONE and held until the next start.
REQ-031 i_start SHALL be ignored outside IDLE.
REQ-032 o_busy=1 in RUN and DONE.
REQ-033 Result outputs SHALL hold their values in IDLE until the next start.

Reset
REQ-034 While rst=1, the state SHALL be IDLE, and tready, busy, done, pass, len_err and timeout SHALL be 0.
REQ-035 While rst=1, all counters and o_first_err SHALL be 0 and the LFSR SHALL be 32'h1.
REQ-036 Reset asserted mid-RUN SHALL abort the run without an o_done pulse; tready falls on the next edge.

Structure
REQ-037 The package nfc_chk_pkg SHALL hold the state enum, the LFSR polynomial constant 32'h80200003 and the TIMEOUT default.
REQ-038 The LFSR SHALL be a sub-module, nfc_lfsr32 (parameter STEPS, combinational next-state), reusable by the write-data generator.

Verification
REQ-039 Seed 1, i_len=16, DATA_WIDTH=32, 4 correct beats, last with tlast -> o_done one cycle after beat 4, pass=1, byte_cnt=16, err_cnt=0.
REQ-040 Same run with beat 2 byte 1 corrupted -> err_cnt=1, first_err=5, pass=0.
REQ-041 i_len=16, tlast on beat 3 -> len_err=1, byte_cnt=12, pass=0.
REQ-042 i_len=16, 4 beats, no tlast -> done after beat 4, len_err=1.
REQ-043 i_len=16, tkeep=4'b0011 on beat 4 with tlast; masked bytes wrong -> byte_cnt=14, err_cnt=0, len_err=1.
REQ-044 TIMEOUT_CYC=100, tvalid held low -> done at cycle 101 of RUN, timeout=1. rst mid-run -> no o_done, all outputs 0.

Source files
------------

// File: rtl/nfc_chk_pkg.sv
// Shared types and constants for the read-data checker and its LFSR.
package nfc_chk_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Galois tap mask for x^32 + x^22 + x^2 + x + 1 (right-shifting form).
   localparam logic [31:0] LFSR_POLY       = 32'h80200003;
   localparam logic [31:0] LFSR_RESET      = 32'h00000001;
   localparam int          TIMEOUT_DEFAULT = 1048576;

   // One right-shift Galois step: when a 1 falls out of bit 0, fold the taps back in.
   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      return s[0] ? ({1'b0, s[31:1]} ^ LFSR_POLY) : {1'b0, s[31:1]};
   endfunction

endpackage

// File: rtl/nfc_lfsr32.sv
// Purely combinational 32-bit Galois LFSR advanced STEPS times.
// Shared with the write-data generator so both ends agree on the pattern.
module nfc_lfsr32
   import nfc_chk_pkg::*;
#(
   parameter int STEPS = 1
) (
   input  logic [31:0] i_state,
   output logic [31:0] o_state
);

   // Unrolled chain of STEPS single steps.
   always_comb begin
      o_state = i_state;
      for (int i = 0; i < STEPS; i++) begin
         o_state = lfsr_step(o_state);
      end
   end

endmodule

// File: rtl/nfc_rdata_checker.sv
// Checks an AXI-Stream read-back against the LFSR pattern and reports
// byte count, mismatches, first mismatch offset, length and timeout errors.
module nfc_rdata_checker
   import nfc_chk_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int TIMEOUT_CYC = TIMEOUT_DEFAULT
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_start,
   input  logic [31:0]             i_seed,
   input  logic [23:0]             i_len,
   input  logic                    s_axis_tvalid,
   output logic                    s_axis_tready,
   input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
   input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
   input  logic                    s_axis_tlast,
   output logic                    o_busy,
   output logic                    o_done,
   output logic                    o_pass,
   output logic [15:0]             o_err_cnt,
   output logic [23:0]             o_first_err,
   output logic [23:0]             o_byte_cnt,
   output logic                    o_len_err,
   output logic                    o_timeout
);

   localparam int LANES = DATA_WIDTH / 32;
   localparam int BYTES = DATA_WIDTH / 8;
   localparam int CW    = $clog2(BYTES + 1);
   localparam int IW    = $clog2(BYTES);

   state_e      state_q, state_d;
   logic [31:0] lfsr_q, lfsr_d;
   logic [23:0] len_q, len_d;
   logic [23:0] byte_cnt_q, byte_cnt_d;
   logic [15:0] err_cnt_q, err_cnt_d;
   logic [23:0] first_err_q, first_err_d;
   logic        len_err_q, len_err_d;
   logic        timeout_q, timeout_d;
   logic        pass_q, pass_d;
   logic [31:0] idle_cnt_q, idle_cnt_d;

   logic [31:0]   lane_exp [LANES];
   logic [31:0]   lfsr_adv;
   logic [CW-1:0] keep_cnt;
   logic [CW-1:0] mism_cnt;
   logic [IW-1:0] first_idx;
   logic [23:0]   byte_sum;
   logic [16:0]   err_sum;
   logic          beat_acc;

   // Lane k expects the pattern advanced k steps from the current register.
   for (genvar k = 0; k < LANES; k++) begin : g_lane
      nfc_lfsr32 #(.STEPS(k)) u_lane (
         .i_state (lfsr_q),
         .o_state (lane_exp[k])
      );
   end

   nfc_lfsr32 #(.STEPS(LANES)) u_adv (
      .i_state (lfsr_q),
      .o_state (lfsr_adv)
   );

   assign beat_acc = s_axis_tvalid && (state_q == RUN);
   assign byte_sum = byte_cnt_q + 24'(keep_cnt);
   assign err_sum  = {1'b0, err_cnt_q} + 17'(mism_cnt);

   // Per-byte compare of kept bytes; scanning high to low leaves the lowest mismatch index.
   always_comb begin
      // NOTE: every variable gets a default before any branch so no latch is inferred.
      keep_cnt  = '0;
      mism_cnt  = '0;
      first_idx = '0;
      for (int b = BYTES - 1; b >= 0; b--) begin
         if (s_axis_tkeep[b]) begin
            keep_cnt = keep_cnt + CW'(1);
            if (s_axis_tdata[8*b +: 8] != lane_exp[b/4][8*(b%4) +: 8]) begin
               mism_cnt  = mism_cnt + CW'(1);
               first_idx = IW'(b);
            end
         end
      end
   end

   // Next-state and result bookkeeping for the IDLE/RUN/DONE sequence.
   always_comb begin
      state_d     = state_q;
      lfsr_d      = lfsr_q;
      len_d       = len_q;
      byte_cnt_d  = byte_cnt_q;
      err_cnt_d   = err_cnt_q;
      first_err_d = first_err_q;
      len_err_d   = len_err_q;
      timeout_d   = timeout_q;
      pass_d      = pass_q;
      idle_cnt_d  = idle_cnt_q;

      case (state_q)
         IDLE: begin
            if (i_start) begin
               len_d       = i_len;
               lfsr_d      = i_seed;
               byte_cnt_d  = '0;
               err_cnt_d   = '0;
               first_err_d = '0;
               len_err_d   = 1'b0;
               timeout_d   = 1'b0;
               pass_d      = 1'b0;
               idle_cnt_d  = '0;
               state_d     = (i_len == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (beat_acc) begin
               lfsr_d     = lfsr_adv;
               byte_cnt_d = byte_sum;
               err_cnt_d  = err_sum[16] ? 16'hFFFF : err_sum[15:0];
               idle_cnt_d = '0;
               if ((err_cnt_q == '0) && (mism_cnt != '0)) begin
                  first_err_d = byte_cnt_q + 24'(first_idx);
               end
               if (s_axis_tlast) begin
                  len_err_d = (byte_sum != len_q);
                  state_d   = DONE;
               end else if (byte_sum >= len_q) begin
                  len_err_d = 1'b1;
                  state_d   = DONE;
               end
            end else if (idle_cnt_q == 32'(TIMEOUT_CYC - 1)) begin
               timeout_d = 1'b1;
               state_d   = DONE;
            end else begin
               idle_cnt_d = idle_cnt_q + 32'd1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Verdict is formed on entry to DONE so it is valid alongside o_done.
      if ((state_q != DONE) && (state_d == DONE)) begin
         pass_d = (err_cnt_d == '0) && !len_err_d && !timeout_d;
      end
   end

   // State and result registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         state_q     <= IDLE;
         lfsr_q      <= LFSR_RESET;
         len_q       <= '0;
         byte_cnt_q  <= '0;
         err_cnt_q   <= '0;
         first_err_q <= '0;
         len_err_q   <= 1'b0;
         timeout_q   <= 1'b0;
         pass_q      <= 1'b0;
         idle_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         lfsr_q      <= lfsr_d;
         len_q       <= len_d;
         byte_cnt_q  <= byte_cnt_d;
         err_cnt_q   <= err_cnt_d;
         first_err_q <= first_err_d;
         len_err_q   <= len_err_d;
         timeout_q   <= timeout_d;
         pass_q      <= pass_d;
         idle_cnt_q  <= idle_cnt_d;
      end
   end

   assign s_axis_tready = (state_q == RUN);
   assign o_busy        = (state_q != IDLE);
   assign o_done        = (state_q == DONE);
   assign o_pass        = pass_q;
   assign o_err_cnt     = err_cnt_q;
   assign o_first_err   = first_err_q;
   assign o_byte_cnt    = byte_cnt_q;
   assign o_len_err     = len_err_q;
   assign o_timeout     = timeout_q;

endmodule
